crc_frame_engine: RTL and testbench
===================================

Name: crc_frame_engine

Overview:
- Parametrised, frame-oriented CRC engine; successor to the fixed 8-bit/8-bit-data CRC-8 (x^8+x^5+x^4+1) LFSR.
- Generic CRC width, polynomial, init, reflection, output XOR and data-beat width.
- Valid/ready stream input with per-beat last and byte keep. Result is held in an output register until handshaken.
- Generate mode emits the CRC. Check mode reports whether a frame with an appended CRC trailer leaves the expected residue.
- Sits between the framer and the link/packet layers.

Parameters:
- CRC_W, 8, CRC width in bits (1..32).
- POLY, 8'h31, generator polynomial, implicit x^CRC_W term omitted.
- INIT, 8'hFF, register value at frame start.
- XOR_OUT, 8'h00, XOR applied to the register to form res_crc.
- REFIN, 0, 1 = each byte processed LSB first; 0 = MSB first.
- REFOUT, 0, 1 = bit-reverse the register before XOR_OUT.
- RESIDUE, 8'h00, expected raw register value (before REFOUT/XOR_OUT) at the end of a good frame in check mode.
- DATA_W, 8, input beat width; a multiple of 8, from 8 to 64.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- crc_clr  in  1  synchronous abort/clear
- mode  in  1  0 = generate, 1 = check; sampled on the first beat of a frame
- s_valid  in  1  input beat valid
- s_ready  out  1  input beat ready
- s_data  in  DATA_W  beat data; byte 0 = s_data[7:0], processed first
- s_keep  in  DATA_W/8  byte enables; honoured on the last beat only
- s_last  in  1  last beat of the frame
- res_valid  out  1  result valid
- res_ready  in  1  result accepted
- res_crc  out  CRC_W  final CRC (after REFOUT/XOR_OUT)
- res_ok  out  1  check mode: raw register == RESIDUE; generate mode: 0
- crc_cur  out  CRC_W  running raw register

Behaviour:
- Reset values:
  - register = INIT, state IDLE.
  - s_ready = 1, res_valid = 0, res_crc = 0, res_ok = 0, crc_cur = INIT.
- States:
  - IDLE: no beat accepted yet in the frame.
  - ACC: at least one beat accepted.
  - DONE: result held.
- Beat acceptance: a beat is accepted when s_valid && s_ready. s_ready = 1 in IDLE/ACC and 0 in DONE. s_ready is registered and has no combinational path from inputs.
- Per accepted beat, the register is updated combinationally over the enabled bytes in one cycle, byte 0 first.
  - Per bit: fb = reg[CRC_W-1] ^ bit; reg = (reg<<1) ^ (fb ? POLY : 0).
  - Bit order within each byte follows REFIN.
- Keep rules:
  - On non-last beats, s_keep is ignored and all bytes are used.
  - On the last beat, s_keep must be contiguous from bit 0. s_keep == 0 closes the frame without adding data.
  - Non-contiguous keep is undefined.
- IDLE→ACC on an accepted beat with s_last = 0; mode is latched on this beat.
- IDLE/ACC→DONE on an accepted beat with s_last = 1.
  - res_valid rises the cycle after that beat.
  - res_crc and res_ok are computed from the final register.
  - The working register reloads INIT in the same cycle.
- Single-beat frame: IDLE→DONE directly, with mode latched on that beat.
- DONE→IDLE on res_valid && res_ready. s_ready returns to 1 the next cycle, so the minimum gap between frames is 1 cycle.
- res_crc and res_ok are stable while res_valid = 1; they retain their last value after the handshake.
- crc_clr, from any state:
  - Next cycle: register = INIT, state IDLE, res_valid = 0, s_ready = 1.
  - Any pending result is dropped.
  - A beat handshaken in the same cycle as crc_clr is discarded; crc_clr has priority.
- rst mid-frame: the partial frame and any pending result are lost; state and register return to reset values.
- Length-0 frame (single last beat, keep = 0): res_crc = REFOUT/XOR_OUT applied to INIT.

Optional Feature:
- Macro: CRC_FRAME_STATS_EN.
- Defined: adds outputs frame_cnt[15:0] and err_cnt[15:0], both reset to 0.
  - frame_cnt increments on each result handshake.
  - err_cnt increments on each result handshake in check mode with res_ok = 0.
  - Both saturate at 16'hFFFF.
  - crc_clr does not clear them; only rst does.
- Undefined: these ports and their logic do not exist.

Test Plan:
- Defaults, mode = 0, ASCII "123456789" as 9 single-byte beats, last on the 9th → res_crc = 8'hF7, res_ok = 0, res_valid one cycle after the last beat.
- Defaults, mode = 1, "123456789" followed by 8'hF7 (10 beats) → res_ok = 1. Same frame with the trailer 8'hF6 → res_ok = 0, and err_cnt = 1 if CRC_FRAME_STATS_EN.
- DATA_W = 32, defaults, beats 32'h34333231, 32'h38373635, then 32'h00000039 with s_keep = 4'b0001 and last → res_crc = 8'hF7.
- CRC_W = 16, POLY = 16'h1021, INIT = 16'hFFFF, "123456789" → res_crc = 16'h29B1. With REFIN = REFOUT = 1, POLY = 16'h1021, INIT = 16'h0000 → 16'h2189.
- Hold res_ready = 0 for 5 cycles after the result → s_ready = 0 and res_crc stable throughout. The next frame's first beat is accepted the cycle after the handshake.
- Pulse crc_clr after 4 of 9 bytes, then send "123456789" → 8'hF7 (abort leaves no residue). rst asserted in DONE → res_valid = 0 and crc_cur = INIT immediately (asynchronous).

Source files
------------

// File: rtl/crc_frame_engine_if.sv
// rtl/crc_frame_engine_if.sv - beat stream and result handshake bundle for crc_frame_engine
interface crc_frame_engine_if #(
  parameter int DATA_W = 8,
  parameter int CRC_W  = 8
);
  logic                mode;
  logic                s_valid;
  logic                s_ready;
  logic [DATA_W-1:0]   s_data;
  logic [DATA_W/8-1:0] s_keep;
  logic                s_last;
  logic                res_valid;
  logic                res_ready;
  logic [CRC_W-1:0]    res_crc;
  logic                res_ok;

  modport master (
    output mode, s_valid, s_data, s_keep, s_last, res_ready,
    input  s_ready, res_valid, res_crc, res_ok
  );

  modport slave (
    input  mode, s_valid, s_data, s_keep, s_last, res_ready,
    output s_ready, res_valid, res_crc, res_ok
  );
endinterface

// File: rtl/crc_frame_engine.sv
// rtl/crc_frame_engine.sv - frame CRC generate/check engine; CRC_FRAME_STATS_EN adds frame_cnt/err_cnt
module crc_frame_engine #(
  parameter int               CRC_W   = 8,
  parameter logic [CRC_W-1:0] POLY    = 8'h31,
  parameter logic [CRC_W-1:0] INIT    = 8'hFF,
  parameter logic [CRC_W-1:0] XOR_OUT = 8'h00,
  parameter bit               REFIN   = 1'b0,
  parameter bit               REFOUT  = 1'b0,
  parameter logic [CRC_W-1:0] RESIDUE = 8'h00,
  parameter int               DATA_W  = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               crc_clr,
  crc_frame_engine_if.slave  bus,
  output logic [CRC_W-1:0]   crc_cur
`ifdef CRC_FRAME_STATS_EN
  ,
  output logic [15:0]        frame_cnt,
  output logic [15:0]        err_cnt
`endif
);

  localparam int NB = DATA_W / 8;

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  state_t           state_q, state_d;
  logic [CRC_W-1:0] crc_q, crc_d;
  logic [CRC_W-1:0] res_crc_q, res_crc_d;
  logic             res_ok_q, res_ok_d;
  logic             mode_q, mode_d;
  logic             s_ready_q;
  logic             res_valid_q;

  logic             beat;
  logic             res_hs;
  logic             frame_mode;
  logic [NB-1:0]    byte_en;
  logic [CRC_W-1:0] crc_next;

  // Bit-serial LFSR step; shift left works for CRC_W = 1 where a slice would not.
  function automatic logic [CRC_W-1:0] crc_byte(input logic [CRC_W-1:0] c, input logic [7:0] d);
    logic [CRC_W-1:0] r;
    logic             fb;
    r = c;
    for (int i = 0; i < 8; i++) begin
      fb = r[CRC_W-1] ^ (REFIN ? d[i] : d[7-i]);
      r  = (r << 1) ^ (fb ? POLY : {CRC_W{1'b0}});
    end
    return r;
  endfunction

  function automatic logic [CRC_W-1:0] crc_beat(input logic [CRC_W-1:0] c,
                                                input logic [DATA_W-1:0] d,
                                                input logic [NB-1:0] en);
    logic [CRC_W-1:0] r;
    r = c;
    for (int b = 0; b < NB; b++) begin
      if (en[b]) r = crc_byte(r, d[8*b +: 8]);
    end
    return r;
  endfunction

  function automatic logic [CRC_W-1:0] reflect(input logic [CRC_W-1:0] c);
    logic [CRC_W-1:0] r;
    for (int i = 0; i < CRC_W; i++) r[i] = c[CRC_W-1-i];
    return r;
  endfunction

  assign beat       = bus.s_valid && s_ready_q;
  assign res_hs     = res_valid_q && bus.res_ready;
  // Keep is contiguous from byte 0, so it doubles as the per-byte enable on the last beat.
  assign byte_en    = bus.s_last ? bus.s_keep : {NB{1'b1}};
  assign crc_next   = crc_beat(crc_q, bus.s_data, byte_en);
  assign frame_mode = (state_q == IDLE) ? bus.mode : mode_q;

  always_comb begin
    state_d   = state_q;
    crc_d     = crc_q;
    mode_d    = mode_q;
    res_crc_d = res_crc_q;
    res_ok_d  = res_ok_q;
    if (crc_clr) begin
      state_d = IDLE;
      crc_d   = INIT;
    end else begin
      case (state_q)
        IDLE, ACC: begin
          if (beat) begin
            mode_d = frame_mode;
            if (bus.s_last) begin
              state_d   = DONE;
              crc_d     = INIT;
              res_crc_d = (REFOUT ? reflect(crc_next) : crc_next) ^ XOR_OUT;
              res_ok_d  = frame_mode && (crc_next == RESIDUE);
            end else begin
              state_d = ACC;
              crc_d   = crc_next;
            end
          end
        end
        DONE: begin
          if (res_hs) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      crc_q       <= INIT;
      mode_q      <= 1'b0;
      res_crc_q   <= '0;
      res_ok_q    <= 1'b0;
      s_ready_q   <= 1'b1;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      crc_q       <= crc_d;
      mode_q      <= mode_d;
      res_crc_q   <= res_crc_d;
      res_ok_q    <= res_ok_d;
      s_ready_q   <= (state_d != DONE);
      res_valid_q <= (state_d == DONE);
    end
  end

  assign bus.s_ready   = s_ready_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_crc   = res_crc_q;
  assign bus.res_ok    = res_ok_q;
  assign crc_cur       = crc_q;

`ifdef CRC_FRAME_STATS_EN
  logic [15:0] frame_cnt_q;
  logic [15:0] err_cnt_q;

  // mode_q still holds the finished frame's mode while the result is pending.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else if (res_hs) begin
      if (frame_cnt_q != 16'hFFFF) frame_cnt_q <= frame_cnt_q + 16'd1;
      if (mode_q && !res_ok_q && (err_cnt_q != 16'hFFFF)) err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign frame_cnt = frame_cnt_q;
  assign err_cnt   = err_cnt_q;
`endif

endmodule

// File: tb/tb_crc_frame_engine.sv
// tb/tb_crc_frame_engine.sv - directed scoreboard bench for crc_frame_engine (CRC-8, CRC-16, 32-bit beats)
module tb_crc_frame_engine;

  logic clk = 1'b0;
  logic rst;
  logic crc_clr;

  always #5 clk = ~clk;

  logic       tv_valid, tv_last, tv_keep, tv_mode, tv_res_ready;
  logic [7:0] tv_data;

  crc_frame_engine_if #(.DATA_W(8),  .CRC_W(8))  if0 ();
  crc_frame_engine_if #(.DATA_W(32), .CRC_W(8))  if1 ();
  crc_frame_engine_if #(.DATA_W(8),  .CRC_W(16)) if2 ();
  crc_frame_engine_if #(.DATA_W(8),  .CRC_W(16)) if3 ();

  assign if0.s_valid = tv_valid;  assign if2.s_valid = tv_valid;  assign if3.s_valid = tv_valid;
  assign if0.s_data  = tv_data;   assign if2.s_data  = tv_data;   assign if3.s_data  = tv_data;
  assign if0.s_keep  = tv_keep;   assign if2.s_keep  = tv_keep;   assign if3.s_keep  = tv_keep;
  assign if0.s_last  = tv_last;   assign if2.s_last  = tv_last;   assign if3.s_last  = tv_last;
  assign if0.mode    = tv_mode;   assign if2.mode    = tv_mode;   assign if3.mode    = tv_mode;
  assign if0.res_ready = tv_res_ready;
  assign if2.res_ready = tv_res_ready;
  assign if3.res_ready = tv_res_ready;

  logic [7:0]  cur0, cur1;
  logic [15:0] cur2, cur3;
`ifdef CRC_FRAME_STATS_EN
  logic [15:0] fc0, ec0, fc1, ec1, fc2, ec2, fc3, ec3;
`endif

  crc_frame_engine u0 (
    .clk(clk), .rst(rst), .crc_clr(crc_clr), .bus(if0.slave), .crc_cur(cur0)
`ifdef CRC_FRAME_STATS_EN
    , .frame_cnt(fc0), .err_cnt(ec0)
`endif
  );

  crc_frame_engine #(.DATA_W(32)) u1 (
    .clk(clk), .rst(rst), .crc_clr(crc_clr), .bus(if1.slave), .crc_cur(cur1)
`ifdef CRC_FRAME_STATS_EN
    , .frame_cnt(fc1), .err_cnt(ec1)
`endif
  );

  crc_frame_engine #(.CRC_W(16), .POLY(16'h1021), .INIT(16'hFFFF), .XOR_OUT(16'h0000),
                     .REFIN(1'b0), .REFOUT(1'b0), .RESIDUE(16'h0000), .DATA_W(8)) u2 (
    .clk(clk), .rst(rst), .crc_clr(crc_clr), .bus(if2.slave), .crc_cur(cur2)
`ifdef CRC_FRAME_STATS_EN
    , .frame_cnt(fc2), .err_cnt(ec2)
`endif
  );

  crc_frame_engine #(.CRC_W(16), .POLY(16'h1021), .INIT(16'h0000), .XOR_OUT(16'h0000),
                     .REFIN(1'b1), .REFOUT(1'b1), .RESIDUE(16'h0000), .DATA_W(8)) u3 (
    .clk(clk), .rst(rst), .crc_clr(crc_clr), .bus(if3.slave), .crc_cur(cur3)
`ifdef CRC_FRAME_STATS_EN
    , .frame_cnt(fc3), .err_cnt(ec3)
`endif
  );

  typedef struct {
    logic [7:0]  crc;
    logic        ok;
    logic        chk16;
    logic [15:0] crc_a;
    logic [15:0] crc_b;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   fails = 0;
  int   last_wait;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic [7:0] d, input logic last, input logic keep, input logic m);
    tv_valid = 1'b1; tv_data = d; tv_last = last; tv_keep = keep; tv_mode = m;
    last_wait = 0;
    while (if0.s_ready !== 1'b1 && last_wait < 50) begin
      @(posedge clk); #1;
      last_wait++;
    end
    if (if0.s_ready !== 1'b1) check("s_ready_wait", {31'b0, if0.s_ready}, 32'd1);
    @(posedge clk); #1;
    tv_valid = 1'b0; tv_last = 1'b0;
  endtask

  // Mode is driven only on the first beat; later beats carry the opposite value.
  task automatic send_str(input string s, input logic m, input logic close);
    for (int i = 0; i < s.len(); i++)
      beat(s[i], close && (i == s.len() - 1), 1'b1, (i == 0) ? m : ~m);
  endtask

  task automatic collect(input int hold);
    exp_t e;
    int   n;
    n = 0;
    while (if0.res_valid !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("res_valid_wait", {31'b0, if0.res_valid}, 32'd1);
    e = sb.pop_front();
    check("res_crc", {24'b0, if0.res_crc}, {24'b0, e.crc});
    check("res_ok", {31'b0, if0.res_ok}, {31'b0, e.ok});
    if (e.chk16) begin
      check("res_crc16_ccitt", {16'b0, if2.res_crc}, {16'b0, e.crc_a});
      check("res_crc16_kermit", {16'b0, if3.res_crc}, {16'b0, e.crc_b});
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_s_ready", {31'b0, if0.s_ready}, 32'd0);
      check("hold_res_crc", {24'b0, if0.res_crc}, {24'b0, e.crc});
    end
    tv_res_ready = 1'b1;
    @(posedge clk); #1;
    tv_res_ready = 1'b0;
    check("res_valid_drop", {31'b0, if0.res_valid}, 32'd0);
  endtask

  task automatic beat32(input logic [31:0] d, input logic last, input logic [3:0] keep);
    int n;
    if1.s_valid = 1'b1; if1.s_data = d; if1.s_last = last; if1.s_keep = keep;
    n = 0;
    while (if1.s_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (if1.s_ready !== 1'b1) check("s_ready32_wait", {31'b0, if1.s_ready}, 32'd1);
    @(posedge clk); #1;
    if1.s_valid = 1'b0; if1.s_last = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   n;
    rst = 1'b1; crc_clr = 1'b0;
    tv_valid = 1'b0; tv_last = 1'b0; tv_keep = 1'b1; tv_mode = 1'b0; tv_data = 8'h00; tv_res_ready = 1'b0;
    if1.s_valid = 1'b0; if1.s_data = '0; if1.s_keep = '0; if1.s_last = 1'b0; if1.mode = 1'b0; if1.res_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    check("rst_s_ready", {31'b0, if0.s_ready}, 32'd1);
    check("rst_res_valid", {31'b0, if0.res_valid}, 32'd0);
    check("rst_res_crc", {24'b0, if0.res_crc}, 32'd0);
    check("rst_res_ok", {31'b0, if0.res_ok}, 32'd0);
    check("rst_crc_cur", {24'b0, cur0}, 32'hFF);
    check("rst_crc_cur16a", {16'b0, cur2}, 32'hFFFF);
    check("rst_crc_cur16b", {16'b0, cur3}, 32'h0000);
`ifdef CRC_FRAME_STATS_EN
    check("rst_frame_cnt", {16'b0, fc0}, 32'd0);
    check("rst_err_cnt", {16'b0, ec0}, 32'd0);
`endif

    sb.push_back('{crc: 8'hF7, ok: 1'b0, chk16: 1'b1, crc_a: 16'h29B1, crc_b: 16'h2189});
    send_str("123456789", 1'b0, 1'b1);
    check("latency_res_valid", {31'b0, if0.res_valid}, 32'd1);
    check("crc_cur_reload", {24'b0, cur0}, 32'hFF);
    collect(0);

    sb.push_back('{crc: 8'h00, ok: 1'b1, chk16: 1'b0, crc_a: 16'h0, crc_b: 16'h0});
    send_str("123456789", 1'b1, 1'b0);
    beat(8'hF7, 1'b1, 1'b1, 1'b0);
    collect(0);

    sb.push_back('{crc: 8'h31, ok: 1'b0, chk16: 1'b0, crc_a: 16'h0, crc_b: 16'h0});
    send_str("123456789", 1'b1, 1'b0);
    beat(8'hF6, 1'b1, 1'b1, 1'b0);
    collect(0);
`ifdef CRC_FRAME_STATS_EN
    check("frame_cnt_3", {16'b0, fc0}, 32'd3);
    check("err_cnt_1", {16'b0, ec0}, 32'd1);
`endif

    sb.push_back('{crc: 8'hF7, ok: 1'b0, chk16: 1'b0, crc_a: 16'h0, crc_b: 16'h0});
    send_str("123456789", 1'b0, 1'b1);
    collect(5);
    check("s_ready_after_hs", {31'b0, if0.s_ready}, 32'd1);

    sb.push_back('{crc: 8'hFF, ok: 1'b0, chk16: 1'b1, crc_a: 16'hFFFF, crc_b: 16'h0000});
    beat(8'h55, 1'b1, 1'b0, 1'b0);
    check("back_to_back_wait", last_wait, 32'd0);
    collect(0);

    send_str("1234", 1'b0, 1'b0);
    crc_clr = 1'b1;
    beat("5", 1'b0, 1'b1, 1'b0);
    crc_clr = 1'b0;
    check("clr_crc_cur", {24'b0, cur0}, 32'hFF);
    check("clr_s_ready", {31'b0, if0.s_ready}, 32'd1);
    sb.push_back('{crc: 8'hF7, ok: 1'b0, chk16: 1'b1, crc_a: 16'h29B1, crc_b: 16'h2189});
    send_str("123456789", 1'b0, 1'b1);
    collect(0);

    sb.push_back('{crc: 8'hF7, ok: 1'b0, chk16: 1'b0, crc_a: 16'h0, crc_b: 16'h0});
    beat32(32'h34333231, 1'b0, 4'b0000);
    beat32(32'h38373635, 1'b0, 4'b0000);
    beat32(32'h00000039, 1'b1, 4'b0001);
    n = 0;
    while (if1.res_valid !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("res_valid32_wait", {31'b0, if1.res_valid}, 32'd1);
    e = sb.pop_front();
    check("res_crc32beat", {24'b0, if1.res_crc}, {24'b0, e.crc});
    if1.res_ready = 1'b1;
    @(posedge clk); #1;
    if1.res_ready = 1'b0;

`ifdef CRC_FRAME_STATS_EN
    check("frame_cnt_6", {16'b0, fc0}, 32'd6);
`endif
    send_str("123456789", 1'b0, 1'b1);
    check("pre_rst_res_valid", {31'b0, if0.res_valid}, 32'd1);
    rst = 1'b1;
    #1;
    check("async_rst_res_valid", {31'b0, if0.res_valid}, 32'd0);
    check("async_rst_s_ready", {31'b0, if0.s_ready}, 32'd1);
    check("async_rst_res_crc", {24'b0, if0.res_crc}, 32'd0);
    check("async_rst_crc_cur", {24'b0, cur0}, 32'hFF);
`ifdef CRC_FRAME_STATS_EN
    check("async_rst_frame_cnt", {16'b0, fc0}, 32'd0);
`endif
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
